// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch front end: a PC register issues one-cycle-latency
//   instruction-memory reads into a small in-order queue. It supports
//   redirects (queue flush and PC reload) and a sticky halt.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   redirect     in   taken jump/branch from a later stage
//   redirect_pc  in   jump target, sampled with redirect
//   halt_in      in   halt decoded; latched until reset
//   imem_req     out  instruction-memory read request
//   imem_addr    out  read address (current pc)
//   imem_rdata   in   read data, one cycle after imem_req
//   out_valid    out  queue head valid
//   out_ready    in   downstream accepts head
//   out_instr    out  head instruction (0 when queue empty)
//   out_pc       out  head PC (0 when queue empty)
//   occupancy    out  number of queued entries
//   halted       out  halt latched and nothing in flight
module fetch_queue_unit #(
    parameter int PC_W     = 5,
    parameter int INSTR_W  = 32,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    input  logic                       halt_in,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(QDEPTH):0]    occupancy,
    output logic                       halted
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    inflight_pc;
    logic               inflight;
    logic               halt_q;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      pending;
    logic               push;
    logic               pop;

    logic [INSTR_W-1:0] instr_mem [QDEPTH];
    logic [PC_W-1:0]    pc_mem    [QDEPTH];

    always_comb begin
        // Entries queued plus the one response that may still arrive:
        // never request more than the queue can absorb.
        pending   = {1'b0, count} + SW'(inflight);
        // rst_n gates the request so nothing is issued while reset is held.
        imem_req  = rst_n & ~halt_q & ~redirect & (pending < SW'(QDEPTH));
        imem_addr = pc;
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        // A response landing in the redirect cycle belongs to the old path.
        push      = inflight & ~redirect;
        out_instr = out_valid ? instr_mem[rd_ptr] : '0;
        out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
        occupancy = count;
        halted    = halt_q & ~inflight;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halt_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc;
                pc          <= pc + PC_W'(1);
            end
            if (halt_in) begin
                halt_q <= 1'b1;
            end
            if (redirect) begin
                // Once halted, a redirect only flushes; fetch stays stopped.
                if (!halt_q) begin
                    pc <= redirect_pc;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Queue storage needs no reset: out_instr/out_pc are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [4:0]  redirect_pc;
    logic        halt_in;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [4:0]  out_pc;
    logic [2:0]  occupancy;
    logic        halted;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [4:0]  sb [$];

    fetch_queue_unit #(.PC_W(5), .INSTR_W(32), .QDEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy), .halted(halted)
    );

    always #5 clk = ~clk;

    // ROM: data = address + 0x100, one cycle after the address.
    always @(posedge clk) imem_rdata <= 32'h100 + 32'(imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every handshake must match the next expected PC.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow: got pc %0h expected none", out_pc);
            end
            if (sb.size() != 0) begin
                logic [4:0] e;
                e = sb.pop_front();
                chk("out_pc", 64'(out_pc), 64'(e));
                chk("out_instr", 64'(out_instr), 64'(32'h100 + 32'(e)));
            end
        end
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_in = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) sb.push_back(5'(i));

        smp();
        chk("rst_req", 64'(imem_req), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_occ", 64'(occupancy), 0);
        chk("rst_halted", 64'(halted), 0);
        chk("rst_instr", 64'(out_instr), 0);
        chk("rst_pc", 64'(out_pc), 0);

        // Streaming from reset
        step(); step(); rst_n = 1'b1;          // cycle 0
        smp();
        chk("c0_req", 64'(imem_req), 1);
        chk("c0_addr", 64'(imem_addr), 0);
        chk("c0_valid", 64'(out_valid), 0);
        step(); smp();                          // cycle 1
        chk("c1_addr", 64'(imem_addr), 1);
        chk("c1_valid", 64'(out_valid), 0);
        step(); smp();                          // cycle 2
        chk("c2_valid", 64'(out_valid), 1);
        for (int i = 3; i < 8; i++) begin
            step(); smp();
            chk("stream_addr", 64'(imem_addr), 64'(i));
        end

        // Backpressure: queue fills, fetch stops, head held
        step(); out_ready = 1'b0; smp();        // cycle 8
        for (int i = 9; i <= 17; i++) begin
            step(); smp();
            if (i == 12) begin
                chk("hold_pc", 64'(out_pc), 6);
                chk("hold_instr", 64'(out_instr), 64'h106);
            end
        end
        chk("full_occ", 64'(occupancy), 4);
        chk("full_req", 64'(imem_req), 0);
        chk("full_valid", 64'(out_valid), 1);
        chk("full_pc", 64'(out_pc), 6);
        step(); out_ready = 1'b1; smp();        // cycle 18
        chk("drain_req0", 64'(imem_req), 0);
        step(); smp();                          // cycle 19
        chk("resume_req", 64'(imem_req), 1);
        chk("resume_addr", 64'(imem_addr), 10);
        step(); smp(); step(); smp();           // cycles 20, 21

        // Redirect with occupancy 3 and a response in flight
        step(); out_ready = 1'b0; smp();        // cycle 22
        step(); redirect = 1'b1; redirect_pc = 5'h10; smp(); // cycle 23
        chk("pre_redir_occ", 64'(occupancy), 3);
        chk("redir_req", 64'(imem_req), 0);
        step(); redirect = 1'b0; out_ready = 1'b1;           // cycle 24
        chk("pops_before_redir", 64'(sb.size()), 0);
        sb.delete();
        for (int i = 16; i < 32; i++) sb.push_back(5'(i));
        for (int i = 0; i <= 6; i++) sb.push_back(5'(i));
        smp();
        chk("flush_occ", 64'(occupancy), 0);
        chk("redir_addr", 64'(imem_addr), 64'h10);
        chk("redir_req1", 64'(imem_req), 1);
        chk("flush_valid", 64'(out_valid), 0);
        step(); smp();                          // cycle 25
        chk("t2_valid", 64'(out_valid), 0);
        step(); smp();                          // cycle 26
        chk("t3_valid", 64'(out_valid), 1);
        chk("t3_pc", 64'(out_pc), 64'h10);

        // PC wrap at 31
        for (int i = 27; i <= 45; i++) begin
            step(); smp();
            if (i == 39) chk("wrap_addr31", 64'(imem_addr), 31);
            if (i == 40) chk("wrap_addr0", 64'(imem_addr), 0);
        end

        // Halt at pc 6
        step(); halt_in = 1'b1; smp();          // cycle 46
        chk("halt_req", 64'(imem_req), 1);
        chk("halt_addr", 64'(imem_addr), 6);
        step(); halt_in = 1'b0; out_ready = 1'b0; smp(); // cycle 47
        chk("halt_noreq", 64'(imem_req), 0);
        chk("halt_inflight", 64'(halted), 0);
        step(); smp();                          // cycle 48
        chk("halted", 64'(halted), 1);
        chk("halt_noreq2", 64'(imem_req), 0);
        chk("halt_occ", 64'(occupancy), 2);
        chk("halt_head", 64'(out_pc), 5);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_occ", 64'(occupancy), 0);
        chk("arst_halted", 64'(halted), 0);
        chk("arst_req", 64'(imem_req), 0);
        chk("sb_left", 64'(sb.size()), 2);
        sb.delete();
        for (int i = 0; i < 4; i++) sb.push_back(5'(i));
        out_ready = 1'b1;
        step(); step(); rst_n = 1'b1;          // cycle 0'
        smp();
        chk("rst2_req", 64'(imem_req), 1);
        chk("rst2_addr", 64'(imem_addr), 0);
        for (int i = 1; i <= 4; i++) begin step(); smp(); end

        // Redirect + halt together, with a pop in the same cycle
        step(); redirect = 1'b1; redirect_pc = 5'h1A; halt_in = 1'b1; smp(); // cycle 5'
        chk("rh_req", 64'(imem_req), 0);
        step(); redirect = 1'b0; halt_in = 1'b0; // cycle 6'
        chk("rh_pop_done", 64'(sb.size()), 0);
        smp();
        chk("rh_occ", 64'(occupancy), 0);
        chk("rh_req2", 64'(imem_req), 0);
        chk("rh_halted", 64'(halted), 1);
        chk("rh_valid", 64'(out_valid), 0);

        // Redirect while halted stays stopped
        step(); redirect = 1'b1; redirect_pc = 5'h05; smp(); // cycle 7'
        chk("hr_req", 64'(imem_req), 0);
        step(); redirect = 1'b0; smp();
        for (int i = 0; i < 3; i++) begin
            chk("hr_req_after", 64'(imem_req), 0);
            chk("hr_valid_after", 64'(out_valid), 0);
            chk("hr_halted", 64'(halted), 1);
            step(); smp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter PC_W, default 5: program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 32: instruction width.
REQ-003 Parameter QDEPTH, default 4 (power of two, >=2): instruction queue depth.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 clk  in  1: single clock; all state updates on rising edge.
REQ-006 rst_n  in  1: reset, asynchronous, active-low.
REQ-007 redirect  in  1: taken jump/branch request from a later stage.
REQ-008 redirect_pc  in  PC_W: jump target, sampled when redirect=1.
REQ-009 halt_in  in  1: halt instruction decoded; sticky once sampled.
REQ-010 imem_req  out  1: instruction-memory read request this cycle.
REQ-011 imem_addr  out  PC_W: read address, valid when imem_req=1.
REQ-012 imem_rdata  in  INSTR_W: read data, valid exactly one cycle after the request.
REQ-013 out_valid  out  1: queue head holds a valid instruction.
REQ-014 out_ready  in  1: downstream accepts the head this cycle.
REQ-015 out_instr  out  INSTR_W: head instruction.
REQ-016 out_pc  out  PC_W: PC of head instruction.
REQ-017 occupancy  out  clog2(QDEPTH)+1: entries currently in queue.
REQ-018 halted  out  1: halt latched and no fetch in flight.

Function
REQ-019 imem_req=1 iff not halt-latched and occupancy+inflight < QDEPTH, where inflight (0/1) is the request issued last cycle; imem_addr = pc register.
REQ-020 On each issued request pc <= pc+1 modulo 2^PC_W (PC_W-bit wrap, no carry-out).
REQ-021 The PC of each request is carried one cycle alongside it; on the following cycle imem_rdata and that PC push into the queue tail unless squashed (REQ-024).
REQ-022 Pop occurs when out_valid & out_ready; push and pop in the same cycle leave occupancy unchanged; full-queue push never occurs by construction (REQ-019).
REQ-023 Latency: request in cycle k -> entry written at end of k+1 -> out_valid in k+2 when queue was empty; sustained throughput one instruction/cycle with out_ready held high.
REQ-024 redirect=1 in cycle t: queue flushed (occupancy 0 in t+1), any in-flight response arriving in t+1 discarded, pc <= redirect_pc; imem_req in t is suppressed; first request to redirect_pc issues in t+1; out_valid earliest t+3.
REQ-025 A pop handshake coinciding with redirect completes for downstream (head counted as consumed) but the flush still empties the queue.
REQ-026 halt_in=1 latches halt at the rising edge; from the next cycle no new requests; an in-flight response still pushes; the queue keeps draining normally.
REQ-027 halted=1 once halt is latched and inflight=0; remains 1 until reset.
REQ-028 redirect while halt-latched flushes the queue but does not change pc or resume fetching.
REQ-029 redirect and halt_in in the same cycle: both take effect (flush, pc<=redirect_pc, halt latched).
REQ-030 out_instr/out_pc hold stable while out_valid=1 and out_ready=0.

Reset
REQ-031 While rst_n=0: pc=RESET_PC, queue empty, inflight=0, halt latch 0, imem_req=0, out_valid=0, occupancy=0, halted=0, out_instr=0, out_pc=0.
REQ-032 Reset asserted mid-operation clears all state immediately (asynchronously); first request to RESET_PC issues in the first cycle after rst_n deasserts.

Verification
REQ-033 Release reset, out_ready=1, ROM returns addr+0x100 -> imem_addr 0,1,2... one per cycle; out_valid from cycle 2; out_pc 0,1,2 with out_instr 0x100,0x101,0x102.
REQ-034 out_ready=0 for 10 cycles -> requests stop with occupancy=4 and inflight=0; out_pc=0 held; release -> entries 0..3 drain in order, fetch resumes at 4 without gaps or duplicates.
REQ-035 Redirect to 0x10 while occupancy=3 and a request is in flight -> occupancy 0 next cycle, stale response dropped, next imem_addr=0x10, next out_pc=0x10 exactly 3 cycles after redirect.
REQ-036 PC reaches 31 (PC_W=5) -> next imem_addr=0, out_pc sequence 30,31,0,1.
REQ-037 halt_in pulse at pc=6 -> no request after that cycle, in-flight entry delivered, halted=1 one cycle later; subsequent redirect flushes queue, imem_req stays 0.
REQ-038 rst_n pulled low with occupancy=2 and halt latched -> out_valid, occupancy, halted zero immediately; after release fetch restarts from RESET_PC.
